// File: rtl/async_reg_pkg.sv
// Shared constants and types for the async_reg8 register family.
package async_reg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

  localparam data_t DEFAULT_RST_VAL = '0;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset bridge: asserts asynchronously, releases on the second clk edge after rst rises.
module rst_sync (
  input  logic clk,
  input  logic rst,
  output logic rst_synced
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_synced = sync[1];

endmodule

// File: rtl/async_reg8.sv
// D-type register with asynchronous active-low reset to RST_VAL.
// Define ASYNC_REG8_RST_SYNC_EN to route rst through a 2-flop synchronised release bridge.
module async_reg8
  import async_reg_pkg::*;
#(
  parameter int unsigned          WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]     RST_VAL = WIDTH'(DEFAULT_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic rst_core;

`ifdef ASYNC_REG8_RST_SYNC_EN
  rst_sync u_rst_sync (
    .clk        (clk),
    .rst        (rst),
    .rst_synced (rst_core)
  );
`else
  assign rst_core = rst;
`endif

  always_ff @(posedge clk or negedge rst_core) begin
    if (!rst_core) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_async_reg8.sv
// Self-checking bench for async_reg8: directed reset/load cases followed by randomized traffic.
module tb_async_reg8;
  import async_reg_pkg::*;

`ifdef ASYNC_REG8_RST_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam data_t RST_VAL = 8'h00;

  logic  clk;
  logic  rst;
  data_t d;
  data_t q;

  int checks;
  int errors;

  // Reference model: expected q plus the number of clk edges seen since rst last went high.
  data_t exp_q;
  int    rel_edges;

  async_reg8 dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("FAIL %s q=%h expected=%h at %0t", tag, q, exp_q, $time);
    end
  endtask

  task automatic set_rst(input logic v);
    rst = v;
    if (!v) begin
      exp_q     = RST_VAL;
      rel_edges = 0;
    end
  endtask

  // Advance to the next rising edge and apply the register's load rule.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      rel_edges++;
      if (rel_edges > SYNC_LAT) exp_q = d;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_q     = 'x;
    rel_edges = 0;
    rst       = 1'b1;
    d         = 8'h01;

    // Load out of reset at the 20 ns edge.
    tick(); #1;
    check("load_out_of_reset");

    // Async reset at 22 ns with no clock edge.
    #1;
    set_rst(1'b0);
    #1;
    check("async_assert");
    d = data_t'($urandom);
    tick(); #1;
    check("hold_in_reset");

    // Release at 78 ns; q must not move before the next edge.
    #17;
    set_rst(1'b1);
    d = 8'h01;
    #1;
    check("release_no_edge");
    tick(); #1;
    check("release_first_edge");

    // Data tracking.
    #21;
    d = 8'h00;
    tick(); #1;
    check("track_zero");
    #37;
    d = 8'h01;
    tick(); #1;
    check("track_one");

    // Glitch on d between edges.
    #17;
    d = 8'h00;
    #4;
    d = 8'h01;
    #1;
    check("glitch_between_edges");
    tick(); #1;
    check("glitch_edge");

    // Reset coinciding with a rising edge: reset wins.
    d = 8'hA5;
    @(posedge clk);
    set_rst(1'b0);
    #1;
    check("reset_at_edge");
    #5;
    set_rst(1'b1);
    tick(); #1;
    check("after_edge_reset");

    // Randomized traffic with mid-cycle resets, releases and d glitches.
    for (int i = 0; i < 300; i++) begin
      #($urandom_range(9, 1));
      d = data_t'($urandom);
      if ($urandom_range(3, 0) == 0) begin
        #2;
        d = data_t'($urandom);
      end
      if (rst && $urandom_range(9, 0) == 0) begin
        #1;
        set_rst(1'b0);
        #1;
        check("rand_async_assert");
      end else if (!rst && $urandom_range(2, 0) == 0) begin
        #1;
        set_rst(1'b1);
      end
      #1;
      check("rand_stable");
      tick(); #1;
      check("rand_edge");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
